sst_xfer_engine: RTL and testbench

//  Initiator side of the mapper save-state (sst) register bus. It drives sst_act,
//  sst_addr, sst_dato and sst_we_reg, and reads sst_di.

---
 rtl/sst_pkg.sv | 24 ++
 rtl/sst_m3_wait.sv | 32 +++
 rtl/sst_xfer_engine.sv | 158 +++++++++++++++
 tb/tb_sst_xfer_engine.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sst_pkg.sv
// Shared types and constants for the mapper save-state transfer engine.
package sst_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_SET,
    ST_RD_OUT,
    ST_WR_IN,
    ST_WR_ARM,
    ST_WR_GAP,
    ST_DONE
  } sst_state_t;

  localparam logic SST_MODE_SAVE = 1'b0;
  localparam logic SST_MODE_LOAD = 1'b1;
  localparam int   SST_IDX_ADDR  = 127;
  localparam int   SST_N_REGS    = 128;

  // DONE is deliberately outside the busy window: busy/sst_act drop with the done pulse.
  function automatic logic sst_is_busy(input sst_state_t s);
    return (s != ST_IDLE) && (s != ST_DONE);
  endfunction

endpackage

// File: rtl/sst_m3_wait.sv
// Waits for the first m3 strobe while armed; flags a timeout after M3_TO armed cycles.
module sst_m3_wait #(
  parameter int M3_TO = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic arm,
  input  logic m3,
  output logic hit,
  output logic tout
);

  localparam int CW = $clog2(M3_TO + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(M3_TO - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Counter restarts from zero on every fresh arm.
  always_comb begin
    cnt_d = '0;
    if (arm && !m3) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign hit  = arm & m3;
  assign tout = arm & ~m3 & (cnt_q == CNT_LAST);

endmodule

// File: rtl/sst_xfer_engine.sv
// Save-state bus initiator: SAVE streams mapper registers to the host,
// LOAD writes host bytes into the mapper with each write committed on an m3 strobe.
module sst_xfer_engine
  import sst_pkg::*;
#(
  parameter int N_REGS   = SST_N_REGS,
  parameter int IDX_ADDR = SST_IDX_ADDR,
  parameter int SETTLE   = 2,
  parameter int M3_TO    = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       m3,
  input  logic       start,
  input  logic       mode,
  input  logic       abort,
  input  logic [7:0] map_idx,
  output logic       busy,
  output logic       done,
  output logic       err,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       sst_act,
  output logic [7:0] sst_addr,
  output logic [7:0] sst_dato,
  output logic       sst_we_reg,
  input  logic [7:0] sst_di
);

  localparam logic [7:0] ADDR_LAST = 8'(N_REGS - 1);
  localparam logic [7:0] ADDR_IDX  = 8'(IDX_ADDR);
  localparam int         SW        = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SW-1:0] SET_LAST = SW'(SETTLE - 1);

  sst_state_t    state_q, state_d;
  logic [7:0]    addr_q, addr_d;
  logic [7:0]    rd_q, rd_d;
  logic [7:0]    dato_q, dato_d;
  logic          err_q, err_d;
  logic [SW-1:0] set_q, set_d;

  logic busy_st, m3_arm, m3_hit, m3_tout;

  assign busy_st = sst_is_busy(state_q);
  assign m3_arm  = (state_q == ST_WR_ARM) & ~abort;

  sst_m3_wait #(.M3_TO(M3_TO)) u_m3_wait (
    .clk  (clk),
    .rst_n(rst_n),
    .arm  (m3_arm),
    .m3   (m3),
    .hit  (m3_hit),
    .tout (m3_tout)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rd_d    = rd_q;
    dato_d  = dato_q;
    err_d   = err_q;
    set_d   = set_q;
    if (busy_st && abort) begin
      err_d   = 1'b1;
      state_d = ST_DONE;
    end else begin
      case (state_q)
        ST_IDLE: if (start) begin
          err_d   = 1'b0;
          addr_d  = '0;
          set_d   = '0;
          state_d = (mode == SST_MODE_LOAD) ? ST_WR_IN : ST_RD_SET;
        end
        ST_RD_SET: begin
          if (set_q == SET_LAST) begin
            rd_d    = sst_di;
            state_d = ST_RD_OUT;
          end else begin
            set_d = set_q + 1'b1;
          end
        end
        ST_RD_OUT: if (out_ready) begin
          if (addr_q == ADDR_LAST) begin
            state_d = ST_DONE;
          end else begin
            addr_d  = addr_q + 8'd1;
            set_d   = '0;
            state_d = ST_RD_SET;
          end
        end
        // The index slot is only compared, never written into the mapper.
        ST_WR_IN: if (in_valid) begin
          dato_d = in_data;
          if (addr_q == ADDR_IDX) begin
            err_d = err_q | (in_data != map_idx);
            if (addr_q == ADDR_LAST) state_d = ST_DONE;
            else                     addr_d  = addr_q + 8'd1;
          end else begin
            state_d = ST_WR_ARM;
          end
        end
        ST_WR_ARM: begin
          if (m3_hit) begin
            state_d = ST_WR_GAP;
          end else if (m3_tout) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end
        end
        ST_WR_GAP: begin
          if (addr_q == ADDR_LAST) begin
            state_d = ST_DONE;
          end else begin
            addr_d  = addr_q + 8'd1;
            state_d = ST_WR_IN;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      rd_q    <= '0;
      dato_q  <= '0;
      err_q   <= 1'b0;
      set_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      dato_q  <= dato_d;
      err_q   <= err_d;
      set_q   <= set_d;
    end
  end

  // Handshake outputs are masked by abort so nothing is exchanged on the abort cycle.
  assign busy       = busy_st;
  assign sst_act    = busy_st;
  assign done       = (state_q == ST_DONE);
  assign err        = err_q;
  assign out_valid  = (state_q == ST_RD_OUT) & ~abort;
  assign in_ready   = (state_q == ST_WR_IN) & ~abort;
  assign sst_we_reg = (state_q == ST_WR_ARM) & ~abort;
  assign out_data   = rd_q;
  assign sst_addr   = addr_q;
  assign sst_dato   = dato_q;

endmodule

// File: tb/tb_sst_xfer_engine.sv
// Directed bench for sst_xfer_engine with a stub mapper (sst_di = ~sst_addr, 128 regs).
module tb_sst_xfer_engine;

  logic       clk = 1'b0;
  logic       rst_n, m3, start, mode, abort;
  logic [7:0] map_idx, in_data, out_data, sst_addr, sst_dato, sst_di;
  logic       busy, done, err, in_valid, in_ready, out_valid, out_ready;
  logic       sst_act, sst_we_reg;

  int checks = 0;
  int failures = 0;

  logic m3_en = 1'b0, m3_kill = 1'b0, reg_clr = 1'b0;
  int   m3_cnt = 0;
  int   done_cnt = 0;
  int   unstable = 0;
  logic       we_p = 1'b0;
  logic [7:0] addr_p = '0, dato_p = '0;
  logic [7:0] regs [128];
  int         commits [128];

  always #5 clk = ~clk;

  sst_xfer_engine dut (
    .clk(clk), .rst_n(rst_n), .m3(m3), .start(start), .mode(mode), .abort(abort),
    .map_idx(map_idx), .busy(busy), .done(done), .err(err),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .sst_act(sst_act), .sst_addr(sst_addr), .sst_dato(sst_dato),
    .sst_we_reg(sst_we_reg), .sst_di(sst_di)
  );

  assign sst_di = ~sst_addr;
  assign m3 = m3_en && (m3_cnt == 0) && !(m3_kill && sst_addr >= 8'd10);

  always @(posedge clk) m3_cnt <= (m3_cnt == 11) ? 0 : m3_cnt + 1;
  always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

  // Stub mapper: commits on m3 & we_reg while in save-state mode.
  always @(posedge clk) begin
    if (reg_clr) begin
      for (int k = 0; k < 128; k++) begin
        regs[k]    <= 8'hEE;
        commits[k] <= 0;
      end
    end else if (m3 && sst_we_reg && sst_act) begin
      regs[sst_addr[6:0]]    <= sst_dato;
      commits[sst_addr[6:0]] <= commits[sst_addr[6:0]] + 1;
    end
  end

  always @(posedge clk) begin
    we_p   <= sst_we_reg;
    addr_p <= sst_addr;
    dato_p <= sst_dato;
    if (we_p && sst_we_reg && (addr_p != sst_addr || dato_p != sst_dato))
      unstable <= unstable + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic sel(input int w);
    case (w)
      0:       return out_valid;
      1:       return in_ready;
      default: return done;
    endcase
  endfunction

  task automatic wait_sig(input int w, input int bound, output bit ok);
    int n = 0;
    while (!sel(w) && n < bound) begin
      tick();
      n++;
    end
    ok = sel(w);
  endtask

  task automatic pulse_start(input logic m);
    mode  = m;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic clear_regs();
    reg_clr = 1'b1;
    tick();
    reg_clr = 1'b0;
  endtask

  task automatic run_save(output int bad);
    bit ok;
    logic [7:0] e;
    bad = 0;
    out_ready = 1'b1;
    pulse_start(1'b0);
    for (int i = 0; i < 128; i++) begin
      wait_sig(0, 20, ok);
      e = ~i[7:0];
      if (!ok || out_data !== e) bad++;
      tick();
    end
    out_ready = 1'b0;
  endtask

  task automatic run_load(input int nbytes, output int bad);
    bit ok;
    bad = 0;
    pulse_start(1'b1);
    for (int i = 0; i < nbytes; i++) begin
      in_data  = i[7:0] ^ 8'h5A;
      in_valid = 1'b1;
      wait_sig(1, 60, ok);
      if (!ok) bad++;
      tick();
      in_valid = 1'b0;
    end
  endtask

  task automatic check_regs(output int bad);
    logic [7:0] e;
    bad = 0;
    for (int i = 0; i < 127; i++) begin
      e = i[7:0] ^ 8'h5A;
      if (regs[i] !== e || commits[i] != 1) bad++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int bad, base, n, n_we;
    bit ok;
    rst_n = 1'b0; start = 1'b0; mode = 1'b0; abort = 1'b0; map_idx = 8'h00;
    in_data = 8'h00; in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) tick();
    chk("reset_outputs", {busy, done, err, in_ready, out_valid, out_data, sst_act,
                          sst_addr, sst_dato, sst_we_reg}, 32'h0);
    rst_n = 1'b1;
    tick();

    // 1: full SAVE, host always ready
    base = done_cnt;
    run_save(bad);
    chk("t1_bytes_bad", bad, 0);
    wait_sig(2, 10, ok);
    chk("t1_done", ok, 1);
    chk("t1_err_act_busy", {err, sst_act, busy}, 3'b000);
    tick();
    chk("t1_done_once", done_cnt - base, 1);

    // 2: SAVE back-pressure at addr 3, stray start ignored, then abort
    out_ready = 1'b0;
    pulse_start(1'b0);
    for (int i = 0; i < 5; i++) begin
      wait_sig(0, 20, ok);
      if (i == 3) begin
        for (int k = 0; k < 5; k++) begin
          chk("t2_hold", {out_valid, out_data, sst_addr}, {1'b1, 8'hFC, 8'h03});
          start = (k == 2);
          mode  = (k == 2);
          tick();
        end
        start = 1'b0;
        mode  = 1'b0;
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
    chk("t2_addr_after", sst_addr, 8'h05);
    base = done_cnt;
    abort = 1'b1;
    tick();
    chk("t2_abort_state", {done, err, busy, sst_act, out_valid}, 5'b11000);
    abort = 1'b0;
    tick();
    chk("t2_err_sticky", {err, busy, done_cnt - base}, {1'b1, 1'b0, 32'd1});

    // 3: full LOAD, matching index byte
    clear_regs();
    map_idx = 8'h25;
    m3_en = 1'b1;
    base = done_cnt;
    run_load(128, bad);
    chk("t3_feed_bad", bad, 0);
    wait_sig(2, 10, ok);
    chk("t3_done", ok, 1);
    chk("t3_err", err, 1'b0);
    tick();
    check_regs(bad);
    chk("t3_regs_bad", bad, 0);
    chk("t3_idx_untouched", {regs[127], commits[127][7:0]}, {8'hEE, 8'h00});
    chk("t3_done_once", done_cnt - base, 1);
    chk("t3_we_stable", unstable, 0);

    // 4: LOAD with index mismatch
    clear_regs();
    map_idx = 8'h5A;
    run_load(128, bad);
    chk("t4_feed_bad", bad, 0);
    wait_sig(2, 10, ok);
    chk("t4_done_err", {ok, err}, 2'b11);
    tick();
    check_regs(bad);
    chk("t4_regs_bad", bad, 0);
    chk("t4_idx_commits", commits[127], 0);

    // 5: m3 stops at addr 10 -> timeout
    clear_regs();
    map_idx = 8'h25;
    m3_kill = 1'b1;
    base = done_cnt;
    run_load(11, bad);
    chk("t5_feed_bad", bad, 0);
    n = 0;
    n_we = 0;
    while (!done && n < 1200) begin
      if (sst_we_reg) n_we++;
      tick();
      n++;
    end
    chk("t5_done", done, 1'b1);
    chk("t5_we_cycles", n_we, 1024);
    chk("t5_err_act_busy", {err, sst_act, busy}, 3'b100);
    tick();
    chk("t5_done_once", done_cnt - base, 1);
    chk("t5_commits", {commits[9][7:0], commits[10][7:0]}, {8'd1, 8'd0});
    m3_kill = 1'b0;

    // 6: async reset during WR_ARM, then a clean SAVE
    m3_en = 1'b0;
    run_load(1, bad);
    chk("t6_in_arm", {bad[7:0], sst_we_reg, sst_act}, {8'd0, 1'b1, 1'b1});
    base = done_cnt;
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_reset", {busy, done, err, in_ready, out_valid, out_data, sst_act,
                           sst_addr, sst_dato, sst_we_reg}, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("t6_no_done", done_cnt - base, 0);
    m3_en = 1'b1;
    run_save(bad);
    chk("t6_save_bad", bad, 0);
    wait_sig(2, 10, ok);
    chk("t6_done_clean", {ok, err}, 2'b10);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
